fixp_block_avg: RTL and testbench

FIXP_BLOCK_AVG -- requirements
Module: fixp_block_avg

---
 rtl/fixp_pkg.sv | 14 +
 rtl/fixp_block_avg_if.sv | 23 ++
 rtl/fixp_minmax_track.sv | 32 +++
 rtl/fixp_block_avg.sv | 128 ++++++++++++
 tb/tb_fixp_block_avg.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fixp_pkg.sv
// Shared types and helpers for the fixed-point block averager.
package fixp_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Accumulator width: enough headroom for 2**log2n full-scale samples.
  function automatic int sum_width(input int wid, input int log2n);
    return wid + log2n;
  endfunction

endpackage

// File: rtl/fixp_block_avg_if.sv
// Sample input and result output handshake bundle of the block averager.
interface fixp_block_avg_if #(
  parameter int WID = 16
);
  logic signed [WID-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [WID-1:0] out_avg;
  logic signed [WID-1:0] out_max;
  logic signed [WID-1:0] out_min;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_avg, out_max, out_min, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_avg, out_max, out_min, out_valid
  );
endinterface

// File: rtl/fixp_minmax_track.sv
// Running signed max/min tracker; load seeds both extremes from value.
module fixp_minmax_track #(
  parameter int WID = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  update,
  input  logic signed [WID-1:0] value,
  output logic signed [WID-1:0] max,
  output logic signed [WID-1:0] min
);

  // Extreme registers: load overrides update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max <= {WID{1'b0}};
      min <= {WID{1'b0}};
    end else if (load) begin
      max <= value;
      min <= value;
    end else if (update) begin
      if (value > max) begin
        max <= value;
      end
      if (value < min) begin
        min <= value;
      end
    end
  end

endmodule

// File: rtl/fixp_block_avg.sv
// Block averager: collects 2**LOG2N signed samples, then holds rounded mean, max and min.
module fixp_block_avg
  import fixp_pkg::*;
#(
  parameter int WID   = 16,
  parameter int FBITS = 8,
  parameter int LOG2N = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  fixp_block_avg_if.slave  bus
);

  localparam int SW = sum_width(WID, LOG2N);
  localparam logic signed [SW-1:0] HALF = SW'(1'b1) << (LOG2N - 1);

  if (LOG2N < 1 || LOG2N > 8 || FBITS < 0 || FBITS > WID) begin : g_param_check
    $error("fixp_block_avg: illegal LOG2N/FBITS parameter");
  end

  state_t                state;
  logic signed [SW-1:0]  sum;
  logic [LOG2N-1:0]      count;
  logic                  ready;
  logic                  valid;
  logic signed [WID-1:0] avg;

  logic                  accept;
  logic                  release_hold;
  logic                  last;
  logic signed [SW-1:0]  sum_next;
  logic signed [SW-1:0]  rounded;
  logic signed [WID-1:0] avg_next;
  logic                  track_load;
  logic                  track_update;
  logic signed [WID-1:0] track_value;
  logic signed [WID-1:0] track_max;
  logic signed [WID-1:0] track_min;

  // Handshake qualifiers and the rounded mean including the sample on the bus.
  always_comb begin
    accept       = (state == ACCUM) && ready && bus.in_valid && !clear;
    release_hold = (state == HOLD) && bus.out_ready;
    last         = (count == {LOG2N{1'b1}});
    sum_next     = sum + SW'(bus.in_data);
    rounded      = sum_next + HALF;
    avg_next     = WID'(rounded >>> LOG2N);
  end

  // Tracker control: seed on the first sample of a block, zero on release.
  always_comb begin
    track_load   = (accept && (count == {LOG2N{1'b0}})) || release_hold;
    track_update = accept && (count != {LOG2N{1'b0}});
    if (release_hold) begin
      track_value = {WID{1'b0}};
    end else begin
      track_value = bus.in_data;
    end
  end

  // Block FSM; ready is registered so the first edge after reset never accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      sum   <= {SW{1'b0}};
      count <= {LOG2N{1'b0}};
      ready <= 1'b0;
      valid <= 1'b0;
      avg   <= {WID{1'b0}};
    end else begin
      case (state)
        ACCUM: begin
          ready <= 1'b1;
          if (clear) begin
            sum   <= {SW{1'b0}};
            count <= {LOG2N{1'b0}};
          end else if (accept) begin
            if (last) begin
              state <= HOLD;
              sum   <= {SW{1'b0}};
              count <= {LOG2N{1'b0}};
              ready <= 1'b0;
              valid <= 1'b1;
              avg   <= avg_next;
            end else begin
              sum   <= sum_next;
              count <= count + LOG2N'(1'b1);
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state <= ACCUM;
            ready <= 1'b1;
            valid <= 1'b0;
          end
        end
        default: begin
          state <= ACCUM;
          sum   <= {SW{1'b0}};
          count <= {LOG2N{1'b0}};
          ready <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

  fixp_minmax_track #(
    .WID(WID)
  ) u_track (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (track_load),
    .update (track_update),
    .value  (track_value),
    .max    (track_max),
    .min    (track_min)
  );

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid;
  assign bus.out_avg   = avg;
  assign bus.out_max   = track_max;
  assign bus.out_min   = track_min;

endmodule

// File: tb/tb_fixp_block_avg.sv
// Self-checking bench for fixp_block_avg (WID=16, LOG2N=2) against a plain-arithmetic block model.
module tb_fixp_block_avg;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  fixp_block_avg_if #(.WID(16)) bus ();

  fixp_block_avg #(
    .WID(16),
    .FBITS(8),
    .LOG2N(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: mean of four integers rounded half toward +inf via floor((sum+2)/4).
  function automatic void ref_block(input logic [15:0] s [4],
                                    output logic [15:0] avg, output logic [15:0] mx,
                                    output logic [15:0] mn);
    int sum, hi, lo, x, num, q;
    sum = 0;
    hi  = $signed(s[0]);
    lo  = $signed(s[0]);
    for (int i = 0; i < 4; i++) begin
      x   = $signed(s[i]);
      sum = sum + x;
      if (x > hi) hi = x;
      if (x < lo) lo = x;
    end
    num = sum + 2;
    q   = num / 4;
    if ((num % 4) != 0 && num < 0) q = q - 1;
    avg = q[15:0];
    mx  = hi[15:0];
    mn  = lo[15:0];
  endfunction

  task automatic feed(input logic [15:0] v, input int gap);
    int n;
    n = 0;
    repeat (gap) @(posedge clk);
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL feed_ready: in_ready=%b required 1 within 20 cycles", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic block_check(input logic [15:0] s [4], input int hold, input bit gaps,
                             input string name);
    logic [15:0] ea, emx, emn;
    ref_block(s, ea, emx, emn);
    bus.out_ready = (hold == 0);
    for (int i = 0; i < 4; i++) feed(s[i], gaps ? int'($urandom_range(0, 2)) : 0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_flags: valid=%b ready=%b required valid=1 ready=0", name,
               bus.out_valid, bus.in_ready);
    end
    checks++;
    if (bus.out_avg !== ea) begin
      failures++;
      $display("FAIL %s_avg: got %h required %h", name, bus.out_avg, ea);
    end
    checks++;
    if (bus.out_max !== emx || bus.out_min !== emn) begin
      failures++;
      $display("FAIL %s_maxmin: got %h/%h required %h/%h", name, bus.out_max, bus.out_min,
               emx, emn);
    end
    // While held: stray samples and clear pulses must not disturb the result.
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'($urandom);
      clear        = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.out_avg, bus.out_max, bus.out_min} !==
          {1'b1, 1'b0, ea, emx, emn}) begin
        failures++;
        $display("FAIL %s_hold%0d: v=%b r=%b %h %h %h required 1 0 %h %h %h", name, k,
                 bus.out_valid, bus.in_ready, bus.out_avg, bus.out_max, bus.out_min,
                 ea, emx, emn);
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    clear         = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_release: valid=%b ready=%b required valid=0 ready=1", name,
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    logic [15:0] s [4];
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    #12;
    checks++;
    if ({bus.out_valid, bus.out_avg, bus.out_max, bus.out_min} !== {1'b0, 48'h0}) begin
      failures++;
      $display("FAIL reset_state: valid=%b avg=%h max=%h min=%h required all 0",
               bus.out_valid, bus.out_avg, bus.out_max, bus.out_min);
    end
    // A sample on the first edge after release must be ignored.
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: in_ready=%b required 1", bus.in_ready);
    end
    for (int i = 0; i < 4; i++) s[i] = 16'h0100;
    block_check(s, 0, 1'b0, "first_edge");
  endtask

  task automatic test_directed();
    logic [15:0] s [4];
    s = '{16'h0100, 16'h0100, 16'h0100, 16'h0100}; block_check(s, 0, 1'b0, "unity");
    s = '{16'h0001, 16'h0001, 16'h0000, 16'h0000}; block_check(s, 0, 1'b0, "round_up");
    s = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000}; block_check(s, 0, 1'b0, "round_neg");
    s = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}; block_check(s, 0, 1'b0, "pos_full");
    s = '{16'h8000, 16'h8000, 16'h8000, 16'h8000}; block_check(s, 0, 1'b0, "neg_full");
  endtask

  task automatic test_hold();
    logic [15:0] s [4];
    s = '{16'h0300, 16'hFD00, 16'h0123, 16'h8001};
    block_check(s, 5, 1'b0, "hold5");
    s = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
    block_check(s, 0, 1'b0, "after_hold");
  endtask

  task automatic test_clear();
    logic [15:0] s [4];
    bus.out_ready = 1'b1;
    feed(16'h0400, 0);
    feed(16'h0400, 0);
    @(negedge clk);
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h7000;
    @(posedge clk);
    #1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_novalid: out_valid=%b required 0", bus.out_valid);
    end
    s = '{16'h0200, 16'h0200, 16'h0200, 16'h0200};
    block_check(s, 0, 1'b0, "after_clear");
  endtask

  task automatic test_reset_mid();
    logic [15:0] s [4];
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) feed(16'h0100, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_avg, bus.out_max, bus.out_min} !== {1'b0, 48'h0}) begin
      failures++;
      $display("FAIL reset_mid: valid=%b avg=%h max=%h min=%h required all 0",
               bus.out_valid, bus.out_avg, bus.out_max, bus.out_min);
    end
    @(negedge clk);
    rst_n = 1'b1;
    s = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
    block_check(s, 0, 1'b0, "post_reset");
    // Reset while a result is pending discards it asynchronously.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) feed(16'h0555, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_avg !== 16'h0000) begin
      failures++;
      $display("FAIL reset_hold: valid=%b avg=%h required 0 0000", bus.out_valid,
               bus.out_avg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    s = '{16'h0004, 16'hFFF0, 16'h0100, 16'h0002};
    block_check(s, 0, 1'b0, "post_reset_hold");
  endtask

  task automatic test_random();
    logic [15:0] s [4];
    int sel;
    for (int b = 0; b < 25; b++) begin
      for (int i = 0; i < 4; i++) begin
        sel = int'($urandom_range(0, 5));
        if (sel == 0)      s[i] = 16'h7FFF;
        else if (sel == 1) s[i] = 16'h8000;
        else               s[i] = 16'($urandom);
      end
      block_check(s, int'($urandom_range(0, 3)), 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_clear();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
